// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the ID->EXE hazard scoreboard.
package hazard_scoreboard_pkg;
   localparam int REG_IDX_W        = 4;
   localparam int NUM_REGS         = 16;
   localparam int SR_IDX           = 16;    // scoreboard slot used for NZCV
   localparam int MAX_INFLIGHT_DEF = 3;
   localparam int CNT_W_DEF        = 2;
   localparam int FL_CNT_W         = 3;     // holds BR_PENALTY-1 for BR_PENALTY up to 7

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // True when a 4-bit register index selects scoreboard slot n.
   function automatic logic sel_hit(input reg_idx_t idx, input int n);
      return (idx == reg_idx_t'(n));
   endfunction
endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One scoreboard slot: saturating up/down count of in-flight writes.
// underflow flags a retire arriving while nothing is outstanding.
module sb_counter
   import hazard_scoreboard_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int MAX_VAL = MAX_INFLIGHT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             underflow
);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_VAL);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Next count: inc and dec together cancel; both ends saturate.
   always_comb begin
      cnt_nxt_s = cnt_r;
      case ({inc, dec})
         2'b10: begin
            if (cnt_r != CNT_MAX) cnt_nxt_s = cnt_r + CNT_ONE;
            else                  cnt_nxt_s = cnt_r;
         end
         2'b01: begin
            if (cnt_r != CNT_ZERO) cnt_nxt_s = cnt_r - CNT_ONE;
            else                   cnt_nxt_s = cnt_r;
         end
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_r <= CNT_ZERO;
      else      cnt_r <= cnt_nxt_s;
   end

   assign cnt       = cnt_r;
   assign underflow = dec & (cnt_r == CNT_ZERO);
endmodule

// File: rtl/hazard_scoreboard.sv
// ID->EXE issue control: RAW/full stalls from a per-register scoreboard,
// plus a branch flush window. No forwarding, so any pending write stalls.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int BR_PENALTY   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_use_src1,
   input  logic                 id_use_src2,
   input  logic                 id_use_sr,
   input  logic [REG_IDX_W-1:0] id_dest,
   input  logic                 id_wb_en,
   input  logic                 id_s,
   input  logic                 exe_b_taken,
   input  logic                 wb_en,
   input  logic [REG_IDX_W-1:0] wb_dest,
   input  logic                 exe_sr_upd,
   output logic                 freeze,
   output logic                 flush,
   output logic                 issue,
   output logic                 err
);
   localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_INFLIGHT);
   localparam logic [FL_CNT_W-1:0] FL_ZERO  = {FL_CNT_W{1'b0}};
   localparam logic [FL_CNT_W-1:0] FL_ONE   = FL_CNT_W'(1);
   localparam logic [FL_CNT_W-1:0] FL_LOAD  = FL_CNT_W'(BR_PENALTY - 1);

   logic [CNT_W-1:0]    reg_cnt_s [NUM_REGS];
   logic [CNT_W-1:0]    sr_cnt_s;
   logic [NUM_REGS-1:0] reg_inc_s;
   logic [NUM_REGS-1:0] reg_dec_s;
   logic [NUM_REGS:0]   uflow_s;
   logic                raw_s, full_s, flush_s, freeze_s, issue_s;
   logic [FL_CNT_W-1:0] fl_cnt_r;
   logic                err_r;

   // Per-register inc/dec strobes; only an issuing instruction claims a slot.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_inc_s[i] = issue_s & id_wb_en & sel_hit(id_dest, i);
         reg_dec_s[i] = wb_en & sel_hit(wb_dest, i);
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      sb_counter #(.CNT_W(CNT_W), .MAX_VAL(MAX_INFLIGHT)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (reg_inc_s[g]),
         .dec       (reg_dec_s[g]),
         .cnt       (reg_cnt_s[g]),
         .underflow (uflow_s[g])
      );
   end

   sb_counter #(.CNT_W(CNT_W), .MAX_VAL(MAX_INFLIGHT)) u_sr_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_s & id_s),
      .dec       (exe_sr_upd),
      .cnt       (sr_cnt_s),
      .underflow (uflow_s[SR_IDX])
   );

   // Hazard decision on pre-update scoreboard; flush overrides any stall.
   always_comb begin
      raw_s   = (id_use_src1 & (reg_cnt_s[id_src1] != CNT_ZERO))
              | (id_use_src2 & (reg_cnt_s[id_src2] != CNT_ZERO))
              | (id_use_sr   & (sr_cnt_s != CNT_ZERO));
      full_s  = (id_wb_en & (reg_cnt_s[id_dest] == CNT_MAX))
              | (id_s     & (sr_cnt_s == CNT_MAX));
      flush_s = exe_b_taken | (fl_cnt_r != FL_ZERO);
      if (flush_s) begin
         freeze_s = 1'b0;
         issue_s  = 1'b0;
      end else if (id_valid) begin
         freeze_s = raw_s | full_s;
         issue_s  = ~(raw_s | full_s);
      end else begin
         freeze_s = 1'b0;
         issue_s  = 1'b0;
      end
   end

   // Flush window: a taken branch (re)loads, otherwise count down to idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   fl_cnt_r <= FL_ZERO;
      else if (exe_b_taken)       fl_cnt_r <= FL_LOAD;
      else if (fl_cnt_r != FL_ZERO) fl_cnt_r <= fl_cnt_r - FL_ONE;
      else                        fl_cnt_r <= fl_cnt_r;
   end

   // Sticky error on any retire against an empty slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          err_r <= 1'b0;
      else if (|uflow_s) err_r <= 1'b1;
      else               err_r <= err_r;
   end

   assign freeze = freeze_s;
   assign flush  = flush_s;
   assign issue  = issue_s;
   assign err    = err_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_hazard_scoreboard;
   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_src1, id_use_src2, id_use_sr, id_wb_en, id_s;
   logic [3:0] id_src1, id_src2, id_dest, wb_dest;
   logic       exe_b_taken, wb_en, exe_sr_upd;
   logic       freeze, flush, issue, err;

   typedef struct {
      string name;
      logic  fr;
      logic  fl;
      logic  is;
      logic  er;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   hazard_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2), .BR_PENALTY(3)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_use_sr(id_use_sr),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_s(id_s), .exe_b_taken(exe_b_taken),
      .wb_en(wb_en), .wb_dest(wb_dest), .exe_sr_upd(exe_sr_upd),
      .freeze(freeze), .flush(flush), .issue(issue), .err(err)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are steady at negedge; pop one expectation per cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if (freeze !== e.fr || flush !== e.fl || issue !== e.is || err !== e.er) begin
            n_err++;
            $display("FAIL %s: got freeze=%b flush=%b issue=%b err=%b, want freeze=%b flush=%b issue=%b err=%b",
                     e.name, freeze, flush, issue, err, e.fr, e.fl, e.is, e.er);
         end
      end
   end

   task automatic expect_out(input string name, input logic fr, input logic fl,
                             input logic is, input logic er);
      exp_t e;
      e.name = name; e.fr = fr; e.fl = fl; e.is = is; e.er = er;
      exp_q.push_back(e);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_valid = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0;
      id_use_src2 = 1'b0; id_use_sr = 1'b0; id_dest = 4'd0; id_wb_en = 1'b0;
      id_s = 1'b0; exe_b_taken = 1'b0; wb_en = 1'b0; wb_dest = 4'd0; exe_sr_upd = 1'b0;
   endtask

   task automatic drive_id(input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                           input logic u2, input logic usr, input logic [3:0] dest,
                           input logic wbe, input logic s);
      id_valid = 1'b1; id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_use_src2 = u2;
      id_use_sr = usr; id_dest = dest; id_wb_en = wbe; id_s = s;
   endtask

   task automatic retire(input logic [3:0] d);
      wb_en = 1'b1; wb_dest = d;
   endtask

   initial begin
      rst = 1'b0;
      clr();
      next_cyc(); expect_out("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      next_cyc(); rst = 1'b1; expect_out("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // 1: build cnt[3]=2, stall on it, then reset mid-operation
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
      expect_out("t1_issue_a", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
      expect_out("t1_issue_b", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); drive_id(4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      expect_out("t1_stall_r3", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); rst = 1'b0;
      expect_out("t1_reset_mid", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); rst = 1'b1;
      expect_out("t1_issue_after_rst", 1'b0, 1'b0, 1'b1, 1'b0);

      // 2: RAW stall on r3, WB does not release in the same cycle
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
      expect_out("t2_add_r3", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); drive_id(4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
      expect_out("t2_raw", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); retire(4'd3);
      expect_out("t2_raw_wb_same", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); wb_en = 1'b0;
      expect_out("t2_release", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); retire(4'd4);
      expect_out("t2_clean_r4", 1'b0, 1'b0, 1'b0, 1'b0);

      // 3: branch during RAW stall, three flush cycles, scoreboard kept
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
      expect_out("t3_add_r3", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); drive_id(4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      expect_out("t3_raw", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); exe_b_taken = 1'b1;
      expect_out("t3_flush0", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc(); exe_b_taken = 1'b0;
      expect_out("t3_flush1", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc(); expect_out("t3_flush2", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc(); expect_out("t3_flush_end_raw", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); retire(4'd3);
      expect_out("t3_wb_r3", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); clr(); exe_b_taken = 1'b1;
      expect_out("t3_reload_a", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc(); exe_b_taken = 1'b1;
      expect_out("t3_reload_b", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc(); exe_b_taken = 1'b0;
      expect_out("t3_reload_c", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc(); expect_out("t3_reload_d", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cyc(); expect_out("t3_reload_end", 1'b0, 1'b0, 1'b0, 1'b0);

      // 4: same-cycle inc and dec on r5 leaves cnt[5]=1
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
      expect_out("t4_add_r5", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); retire(4'd5);
      expect_out("t4_inc_dec", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      expect_out("t4_src2_stall", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); retire(4'd5);
      expect_out("t4_wb_r5", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); wb_en = 1'b0;
      expect_out("t4_release", 1'b0, 1'b0, 1'b1, 1'b0);

      // 5: saturation on r7
      for (int i = 0; i < 3; i++) begin
         next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
         expect_out("t5_fill_r7", 1'b0, 1'b0, 1'b1, 1'b0);
      end
      next_cyc(); expect_out("t5_full", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); retire(4'd7);
      expect_out("t5_full_wb_same", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); wb_en = 1'b0;
      expect_out("t5_issue_after_wb", 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         next_cyc(); clr(); retire(4'd7);
         expect_out("t5_drain_r7", 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // 6: status register dependency, then underflow error
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      expect_out("t6_cmp_s", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); drive_id(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
      expect_out("t6_moveq_stall", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); exe_sr_upd = 1'b1;
      expect_out("t6_sr_upd_same", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cyc(); exe_sr_upd = 1'b0;
      expect_out("t6_moveq_issue", 1'b0, 1'b0, 1'b1, 1'b0);
      next_cyc(); clr(); retire(4'd1);
      expect_out("t6_clean_r1", 1'b0, 1'b0, 1'b0, 1'b0);
      next_cyc(); retire(4'd0);
      expect_out("t6_wb_r0_empty", 1'b0, 1'b0, 1'b0, 1'b0);
      next_cyc(); clr();
      expect_out("t6_err_set", 1'b0, 1'b0, 1'b0, 1'b1);
      next_cyc(); expect_out("t6_err_sticky", 1'b0, 1'b0, 1'b0, 1'b1);
      next_cyc(); rst = 1'b0;
      expect_out("t6_err_reset", 1'b0, 1'b0, 1'b0, 1'b0);
      next_cyc(); rst = 1'b1;

      // Let the monitor drain within a bounded number of cycles.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
